// File: rtl/mdu_sequencer.sv
// mdu_sequencer: shift-add MULTU sequencer that writes the HiLo product and stalls the pipeline while busy
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc, acc_add, acc_nx;
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    acc_add  = acc[0] ? {acc[2*WIDTH:WIDTH] + {1'b0, mcand}, acc[WIDTH-1:0]} : acc;
    acc_nx   = acc_add >> 1;
    last     = cnt == CW'(WIDTH - 1);
    state_nx = flush ? IDLE :
               state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  assign busy    = state != IDLE;
  assign stall   = (start || mf_req) && busy;
  // the write is dropped if this DONE cycle is squashed or reset
  assign hilo_we = state == DONE && !flush && rst;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && !flush) begin
        mcand <= op_a;
        acc   <= {{(WIDTH+1){1'b0}}, op_b};
        cnt   <= '0;
      end
      if (state == RUN && !flush) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        if (last) {hi_wdata, lo_wdata} <= acc_nx[2*WIDTH-1:0];
      end
    end
  end
endmodule
